rr_bus_arbiter: RTL and testbench
=================================

Name: rr_bus_arbiter

Overview:
- N-master round-robin arbiter for the system bus; replaces fixed-priority 2-master arbitration where fairness is required.
- Grants one master at a time, drives `bus_grant` and `slave_sel` to the address/data mux and slave decoders, and holds the grant until `trans_done`.
- A watchdog reclaims the bus from a stalled transaction. A mandatory one-cycle dead time separates successive owners.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- SLAVE_SEL_W, 2, width of one master's slave-select field.
- TIMEOUT_CYCLES, 16, max BUSY cycles before forced release; 0 disables the watchdog.
- GID_W, $clog2(NUM_MASTERS+1), width of `bus_grant` (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_request  in  NUM_MASTERS  bit i = master i requests the bus (level, held until done).
- m_slave_sel  in  NUM_MASTERS*SLAVE_SEL_W  master i target slave at [i*SLAVE_SEL_W +: SLAVE_SEL_W].
- trans_done  in  1  current slave/master signals transaction complete (single-cycle pulse).
- m_grant  out  NUM_MASTERS  one-hot grant, registered.
- bus_busy  out  1  high whenever any grant is active.
- bus_grant  out  GID_W  1-based index of granted master; 0 = none.
- slave_sel  out  SLAVE_SEL_W  slave selected by granted master; 0 when idle.
- timeout_err  out  1  one-cycle pulse when watchdog forced a release.

Behaviour:
- Reset (async, immediate): state=IDLE; m_grant=0, bus_busy=0, bus_grant=0, slave_sel=0, timeout_err=0.
  - Watchdog count=0.
  - RR pointer last_id=NUM_MASTERS-1, so master 0 wins the first arbitration.
- States: IDLE, BUSY, RELEASE. All outputs registered.
- IDLE: if `m_request` is nonzero, select the first set bit searching from last_id+1 upward with wrap-around. At the next edge:
  - m_grant[sel]=1, bus_grant=sel+1, bus_busy=1.
  - slave_sel latched from that master's field; watchdog=0; state=BUSY.
  - Latency: request sampled high at edge E yields grant visible after E.
- BUSY:
  - `slave_sel` and `bus_grant` stay frozen for the whole tenure; changes on `m_slave_sel` are ignored.
  - trans_done=1: next edge → RELEASE.
  - Else granted master's request=0 (abandon): next edge → RELEASE.
  - Else if TIMEOUT_CYCLES≠0 and watchdog==TIMEOUT_CYCLES-1: next edge → RELEASE with timeout_err=1.
  - Else watchdog+1 (saturates; never wraps).
  - Priority when simultaneous: trans_done > abandon > timeout. trans_done and timeout in the same cycle gives no timeout_err.
- Entering RELEASE (same edge):
  - m_grant=0, bus_busy=0, bus_grant=0, slave_sel=0; last_id=granted index.
  - timeout_err is high only during the RELEASE cycle.
- RELEASE: unconditional → IDLE next edge; timeout_err returns to 0.
- Turnaround: grant drops at edge E, new owner granted at E+2 earliest. Two owners never overlap.
- `trans_done` outside BUSY is ignored.
- Requests from non-granted masters while BUSY are ignored (no queuing beyond the level request itself).
- A request dropped in IDLE before sampling is never granted.
- Reset asserted mid-BUSY: all outputs clear asynchronously; pointer returns to master 0 first.

Optional Feature:
- Macro ARB_LOCK_EN.
- Defined: adds input `m_lock` [NUM_MASTERS]. If trans_done=1 in BUSY while m_lock[granted]=1 and m_request[granted]=1:
  - Stay in BUSY, re-latch slave_sel from the granted master's field, clear watchdog.
  - No dead cycle; last_id is not updated.
  - Watchdog timeout still forces RELEASE regardless of lock.
- Not defined: no `m_lock` port; every trans_done releases the bus.

Test Plan:
- Reset then m_request=4'b0001, m_slave_sel[1:0]=2'd3 → one edge later m_grant=0001, bus_grant=1, slave_sel=3, bus_busy=1; trans_done pulse → all outputs 0 next edge.
- m_request=4'b1111 held, trans_done pulsed 2 cycles after each grant → bus_grant sequence 1,2,3,4,1, with exactly 2 non-granted cycles between owners.
- m_request=4'b0101, last owner master 0 → master 2 granted (bus_grant=3) before master 0 again.
- TIMEOUT_CYCLES=8, grant master 1, no trans_done → grant held 8 cycles, then release with timeout_err=1 for exactly 1 cycle; trans_done and timeout coincident → timeout_err stays 0.
- Master 3 granted, m_slave_sel for master 3 changed 1→2 mid-tenure → slave_sel stays 1; master 3 drops request → release next edge with no timeout_err.
- rst pulsed while BUSY → outputs 0 without a clock edge; next m_request=4'b1010 grants master 1 (bus_grant=2).

Source files
------------

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: N-master round-robin bus arbiter with watchdog and one-cycle dead time.
// Optional bus locking across back-to-back transactions when ARB_LOCK_EN is defined.
module rr_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int SLAVE_SEL_W    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_MASTERS-1:0]                      m_request,
    input  logic [NUM_MASTERS*SLAVE_SEL_W-1:0]          m_slave_sel,
    input  logic                                        trans_done,
`ifdef ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]                      m_lock,
`endif
    output logic [NUM_MASTERS-1:0]                      m_grant,
    output logic                                        bus_busy,
    output logic [$clog2(NUM_MASTERS+1)-1:0]            bus_grant,
    output logic [SLAVE_SEL_W-1:0]                      slave_sel,
    output logic                                        timeout_err
);
    localparam int GID_W = $clog2(NUM_MASTERS + 1);
    localparam int IDW   = $clog2(NUM_MASTERS);
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                 state, n_state;
    logic [IDW-1:0]         last_id, n_last, cur, n_cur, sel;
    logic [WD_W-1:0]        wd, n_wd;
    logic [NUM_MASTERS-1:0] n_grant;
    logic                   n_busy, n_to, found, wd_hit, hold;
    logic [GID_W-1:0]       n_bg;
    logic [SLAVE_SEL_W-1:0] n_ss;
    logic [SLAVE_SEL_W-1:0] fld [NUM_MASTERS];
    int                     idx;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_fld
        assign fld[i] = m_slave_sel[i*SLAVE_SEL_W +: SLAVE_SEL_W];
    end

    assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd == WD_W'(TIMEOUT_CYCLES - 1));
`ifdef ARB_LOCK_EN
    assign hold = trans_done && m_lock[cur] && m_request[cur] && !wd_hit;
`else
    assign hold = 1'b0;
`endif

    // Round-robin search starting just after the previous owner
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_id) + k) % NUM_MASTERS;
            if (!found && m_request[IDW'(idx)]) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        n_state = state;
        n_grant = m_grant;
        n_busy  = bus_busy;
        n_bg    = bus_grant;
        n_ss    = slave_sel;
        n_to    = 1'b0;
        n_wd    = wd;
        n_last  = last_id;
        n_cur   = cur;
        case (state)
            IDLE: if (found) begin
                n_state = BUSY;
                n_grant = NUM_MASTERS'(1) << sel;
                n_bg    = GID_W'(sel) + GID_W'(1);
                n_busy  = 1'b1;
                n_ss    = fld[sel];
                n_wd    = '0;
                n_cur   = sel;
            end
            BUSY: if (hold) begin
                n_ss = fld[cur];
                n_wd = '0;
            end else if (trans_done || !m_request[cur] || wd_hit) begin
                n_state = RELEASE;
                n_grant = '0;
                n_busy  = 1'b0;
                n_bg    = '0;
                n_ss    = '0;
                n_last  = cur;
                n_to    = wd_hit && !trans_done && m_request[cur];
            end else begin
                n_wd = (wd == '1) ? wd : wd + WD_W'(1);
            end
            default: n_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            m_grant     <= '0;
            bus_busy    <= 1'b0;
            bus_grant   <= '0;
            slave_sel   <= '0;
            timeout_err <= 1'b0;
            wd          <= '0;
            last_id     <= IDW'(NUM_MASTERS - 1);
            cur         <= '0;
        end else begin
            state       <= n_state;
            m_grant     <= n_grant;
            bus_busy    <= n_busy;
            bus_grant   <= n_bg;
            slave_sel   <= n_ss;
            timeout_err <= n_to;
            wd          <= n_wd;
            last_id     <= n_last;
            cur         <= n_cur;
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed and randomized checks of rr_bus_arbiter against a tenure-level model.
module tb_rr_bus_arbiter;
    localparam int N = 4;
    localparam int W = 2;
    localparam int T = 8;

    logic           clk = 0;
    logic           rst = 1;
    logic [N-1:0]   m_request = '0;
    logic [N*W-1:0] m_slave_sel = '0;
    logic           trans_done = 0;
    logic [N-1:0]   m_grant;
    logic           bus_busy;
    logic [2:0]     bus_grant;
    logic [W-1:0]   slave_sel;
    logic           timeout_err;
`ifdef ARB_LOCK_EN
    logic [N-1:0]   m_lock = '0;
`endif

    rr_bus_arbiter #(.NUM_MASTERS(N), .SLAVE_SEL_W(W), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .m_request(m_request), .m_slave_sel(m_slave_sel),
        .trans_done(trans_done),
`ifdef ARB_LOCK_EN
        .m_lock(m_lock),
`endif
        .m_grant(m_grant), .bus_busy(bus_busy), .bus_grant(bus_grant),
        .slave_sel(slave_sel), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    // Model: current owner (-1 = none), previous owner, cycles held, dead-time flag
    int       owner = -1;
    int       last  = N - 1;
    int       ten   = 0;
    bit       dead  = 0;
    bit       mto   = 0;
    logic [W-1:0] mss = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = -1; last = N - 1; ten = 0; dead = 0; mto = 0; mss = '0;
    endtask

    task automatic model_edge();
        mto = 0;
        if (owner >= 0) begin
            if (trans_done || !m_request[owner] || ten == T - 1) begin
                mto   = !trans_done && m_request[owner] && ten == T - 1;
                last  = owner;
                owner = -1;
                dead  = 1;
            end else ten++;
        end else if (dead) dead = 0;
        else if (m_request != 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_request[(last + k) % N]) begin
                    owner = (last + k) % N;
                    break;
                end
            end
            ten = 0;
            mss = m_slave_sel[owner*W +: W];
        end
    endtask

    task automatic check_model();
        chk("grant",   32'(m_grant),     owner >= 0 ? 32'(1) << owner : 0);
        chk("busy",    32'(bus_busy),    owner >= 0 ? 1 : 0);
        chk("bus_gnt", 32'(bus_grant),   32'(owner + 1));
        chk("sel",     32'(slave_sel),   owner >= 0 ? 32'(mss) : 0);
        chk("timeout", 32'(timeout_err), 32'(mto));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; m_request = '0; trans_done = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    int gap, cyc;

    initial begin
        #12;
        chk("rst_outs", {m_grant, bus_busy, bus_grant, slave_sel, timeout_err}, 0);
        do_reset();
        // Single master grant and release
        m_request = 4'b0001; m_slave_sel = 8'h03;
        step();
        chk("t1_grant", 32'(m_grant), 1);
        chk("t1_bg", 32'(bus_grant), 1);
        chk("t1_sel", 32'(slave_sel), 3);
        trans_done = 1; step(); trans_done = 0; m_request = '0;
        chk("t1_rel", {m_grant, bus_busy, bus_grant, slave_sel, timeout_err}, 0);
        step();
        // Full rotation with two dead cycles between owners
        do_reset();
        m_request = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            gap = 0;
            while (!bus_busy && gap < 10) begin gap++; step(); end
            chk("t2_bg", 32'(bus_grant), 32'(g % 4 + 1));
            if (g > 0) chk("t2_gap", 32'(gap), 2);
            step(); trans_done = 1; step(); trans_done = 0;
        end
        // Pointer skips past master 0 to master 2
        do_reset();
        m_request = 4'b0001; step();
        trans_done = 1; step(); trans_done = 0;
        m_request = 4'b0101; step(); step();
        chk("t3_m2", 32'(bus_grant), 3);
        trans_done = 1; step(); trans_done = 0; step(); step();
        chk("t3_m0", 32'(bus_grant), 1);
        // Watchdog release and timeout pulse width
        do_reset();
        m_request = 4'b0010; step();
        chk("t4_bg", 32'(bus_grant), 2);
        cyc = 1;
        while (bus_busy && cyc < 20) begin step(); if (bus_busy) cyc++; end
        chk("t4_held", 32'(cyc), 8);
        chk("t4_to", 32'(timeout_err), 1);
        step();
        chk("t4_to_clr", 32'(timeout_err), 0);
        step();
        chk("t4_regrant", 32'(bus_grant), 2);
        repeat (7) step();
        trans_done = 1; step(); trans_done = 0;
        chk("t4_coinc_to", 32'(timeout_err), 0);
        chk("t4_coinc_busy", 32'(bus_busy), 0);
        // Frozen slave_sel and abandonment
        do_reset();
        m_request = 4'b1000; m_slave_sel = 8'h40; step();
        chk("t5_sel", 32'(slave_sel), 1);
        m_slave_sel = 8'h80; step(); step();
        chk("t5_frozen", 32'(slave_sel), 1);
        m_request = '0; step();
        chk("t5_rel", {m_grant, bus_busy, timeout_err}, 0);
        // Asynchronous reset mid-tenure
        do_reset();
        m_request = 4'b1000; step();
        chk("t6_busy", 32'(bus_busy), 1);
        #2 rst = 1;
        #1 chk("t6_async", {m_grant, bus_busy, bus_grant, slave_sel, timeout_err}, 0);
        model_reset();
        @(negedge clk);
        rst = 0; m_request = 4'b1010; step();
        chk("t6_bg", 32'(bus_grant), 2);
        // Randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) m_request = N'($urandom);
            trans_done  = ($urandom_range(0, 5) == 0);
            m_slave_sel = (N*W)'($urandom);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
